// File: rtl/tag_alloc_ctrl_pkg.sv
// Shared types for the tag allocation controller: engine states and tag-width derivation.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package tag_alloc_ctrl_pkg;

    // Per-stage engine state: a stage either waits for its tag or is working on it
    typedef enum logic [0:0] {
        ENG_IDLE = 1'b0,
        ENG_BUSY = 1'b1
    } eng_state_e;

    localparam int DEF_NUM_TAG = 2;

    // Tag index width for a given tag count; never narrower than one bit
    function automatic int tag_w_of(input int num_tag);
        return (num_tag <= 2) ? 1 : $clog2(num_tag);
    endfunction

endpackage

// File: rtl/tag_stage_sched.sv
// Per-stage engine scheduler: walks tags in allocation order and starts the engine on ready tags.
// Latency: start pulses one cycle after the tag's ready flag; done vector is combinational with done_i.
// Backpressure: waits in IDLE until the current tag is ready; done outside BUSY is ignored.
module tag_stage_sched
    import tag_alloc_ctrl_pkg::*;
#(
    parameter int NUM_TAG     = DEF_NUM_TAG,
    parameter int TAG_W       = tag_w_of(NUM_TAG),
    parameter bit ADV_ON_NEXT = 1'b0,
    parameter bit ENABLED     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_TAG-1:0] tag_ready_vec_i,
    input  logic [NUM_TAG-1:0] next_tag_vec_i,
    input  logic               done_i,
    output logic               start_o,
    output logic [TAG_W-1:0]   tag_o,
    output logic [NUM_TAG-1:0] tag_done_vec_o,
    output logic               idle_o
);

    eng_state_e         state_q, state_d;
    logic [TAG_W-1:0]   ptr_q, ptr_d;
    logic [TAG_W-1:0]   ptr_inc;
    logic               start_q, start_d;

    // Pointer wraps explicitly so a wider-than-needed TAG_W still cycles through NUM_TAG tags
    assign ptr_inc = (ptr_q == TAG_W'(NUM_TAG - 1)) ? '0 : ptr_q + 1'b1;

    // State register: engine state, tag pointer and the registered start pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENG_IDLE;
            ptr_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            start_q <= start_d;
        end
    end

    // Next state: a hand-off on the current tag wins over starting another pass on it
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        start_d = 1'b0;
        unique case (state_q)
            ENG_IDLE: begin
                if (ENABLED) begin
                    if (ADV_ON_NEXT && next_tag_vec_i[ptr_q]) begin
                        ptr_d = ptr_inc;
                    end else if (tag_ready_vec_i[ptr_q]) begin
                        state_d = ENG_BUSY;
                        start_d = 1'b1;
                    end
                end
            end
            ENG_BUSY: begin
                if (done_i) begin
                    state_d = ENG_IDLE;
                    // Compute stays on its tag so reuse passes land on the same buffer
                    if (!ADV_ON_NEXT) begin
                        ptr_d = ptr_inc;
                    end
                end
            end
            default: state_d = ENG_IDLE;
        endcase
    end

    // Outputs: done pulse only for a completion seen while the engine is actually busy
    always_comb begin
        tag_done_vec_o = '0;
        if (state_q == ENG_BUSY && done_i) begin
            tag_done_vec_o[ptr_q] = 1'b1;
        end
        idle_o  = (state_q == ENG_IDLE);
        start_o = start_q;
        tag_o   = ptr_q;
    end

endmodule

// File: rtl/tag_alloc_ctrl.sv
// Double-buffer tag allocator: hands out tags round-robin and schedules load/compute/store engines per tag.
// Latency: tag_req/reuse/flush pulse one cycle after the block request; engine starts one cycle after tag ready.
// Backpressure: block_ready drops while the next tag is busy or a tag_req pulse is in flight; block_start is then ignored.
module tag_alloc_ctrl
    import tag_alloc_ctrl_pkg::*;
#(
    parameter int NUM_TAG       = DEF_NUM_TAG,
    parameter int TAG_W         = tag_w_of(NUM_TAG),
    parameter bit STORE_ENABLED = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               block_start,
    input  logic               block_reuse,
    input  logic               block_flush,
    input  logic               block_bias_prev_sw,
    input  logic               block_ddr_pe_sw,
    output logic               block_ready,
    output logic [NUM_TAG-1:0] tag_req,
    output logic [NUM_TAG-1:0] tag_reuse,
    output logic [NUM_TAG-1:0] tag_flush,
    output logic               tag_bias_prev_sw,
    output logic               tag_ddr_pe_sw,
    input  logic [NUM_TAG-1:0] tag_ready_vec,
    input  logic [NUM_TAG-1:0] ldmem_tag_ready_vec,
    input  logic [NUM_TAG-1:0] compute_tag_ready_vec,
    input  logic [NUM_TAG-1:0] stmem_tag_ready_vec,
    input  logic [NUM_TAG-1:0] next_compute_tag_vec,
    output logic [NUM_TAG-1:0] ldmem_tag_done_vec,
    output logic [NUM_TAG-1:0] compute_tag_done_vec,
    output logic [NUM_TAG-1:0] stmem_tag_done_vec,
    output logic               ldmem_start,
    output logic               compute_start,
    output logic               stmem_start,
    output logic [TAG_W-1:0]   ldmem_tag,
    output logic [TAG_W-1:0]   compute_tag,
    output logic [TAG_W-1:0]   stmem_tag,
    input  logic               ldmem_done,
    input  logic               compute_done,
    input  logic               stmem_done,
    output logic               all_idle
);

    logic [TAG_W-1:0]   alloc_ptr_q, alloc_ptr_d;
    logic [TAG_W-1:0]   last_ptr_q, last_ptr_d;
    logic               last_vld_q, last_vld_d;
    logic [NUM_TAG-1:0] tag_req_q, tag_req_d;
    logic [NUM_TAG-1:0] tag_reuse_q, tag_reuse_d;
    logic [NUM_TAG-1:0] tag_flush_q, tag_flush_d;
    logic               bias_q, bias_d;
    logic               ddr_q, ddr_d;
    logic               req_accept;
    logic               ld_idle, cmp_idle, st_idle;

    function automatic logic [NUM_TAG-1:0] onehot(input logic [TAG_W-1:0] idx);
        logic [NUM_TAG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // One allocation per tag_req pulse keeps the tag manager from seeing two requests merge
    assign block_ready = tag_ready_vec[alloc_ptr_q] && (tag_req_q == '0);
    assign req_accept  = block_start && block_ready;

    // Allocation bookkeeping; reuse/flush read last_ptr before a same-cycle start moves it
    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        last_ptr_d  = last_ptr_q;
        last_vld_d  = last_vld_q;
        tag_req_d   = '0;
        tag_reuse_d = '0;
        tag_flush_d = '0;
        bias_d      = bias_q;
        ddr_d       = ddr_q;
        if (block_reuse && last_vld_q) begin
            tag_reuse_d = onehot(last_ptr_q);
            bias_d      = block_bias_prev_sw;
            ddr_d       = block_ddr_pe_sw;
        end
        if (block_flush && last_vld_q) begin
            tag_flush_d = onehot(last_ptr_q);
        end
        if (req_accept) begin
            tag_req_d   = onehot(alloc_ptr_q);
            bias_d      = block_bias_prev_sw;
            ddr_d       = block_ddr_pe_sw;
            last_ptr_d  = alloc_ptr_q;
            last_vld_d  = 1'b1;
            alloc_ptr_d = (alloc_ptr_q == TAG_W'(NUM_TAG - 1)) ? '0 : alloc_ptr_q + 1'b1;
        end
    end

    // Allocation registers and the single-cycle per-tag pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alloc_ptr_q <= '0;
            last_ptr_q  <= '0;
            last_vld_q  <= 1'b0;
            tag_req_q   <= '0;
            tag_reuse_q <= '0;
            tag_flush_q <= '0;
            bias_q      <= 1'b0;
            ddr_q       <= 1'b0;
        end else begin
            alloc_ptr_q <= alloc_ptr_d;
            last_ptr_q  <= last_ptr_d;
            last_vld_q  <= last_vld_d;
            tag_req_q   <= tag_req_d;
            tag_reuse_q <= tag_reuse_d;
            tag_flush_q <= tag_flush_d;
            bias_q      <= bias_d;
            ddr_q       <= ddr_d;
        end
    end

    assign tag_req          = tag_req_q;
    assign tag_reuse        = tag_reuse_q;
    assign tag_flush        = tag_flush_q;
    assign tag_bias_prev_sw = bias_q;
    assign tag_ddr_pe_sw    = ddr_q;

    tag_stage_sched #(
        .NUM_TAG     (NUM_TAG),
        .TAG_W       (TAG_W),
        .ADV_ON_NEXT (1'b0),
        .ENABLED     (1'b1)
    ) u_ldmem (
        .clk             (clk),
        .rst             (reset),
        .tag_ready_vec_i (ldmem_tag_ready_vec),
        .next_tag_vec_i  ('0),
        .done_i          (ldmem_done),
        .start_o         (ldmem_start),
        .tag_o           (ldmem_tag),
        .tag_done_vec_o  (ldmem_tag_done_vec),
        .idle_o          (ld_idle)
    );

    tag_stage_sched #(
        .NUM_TAG     (NUM_TAG),
        .TAG_W       (TAG_W),
        .ADV_ON_NEXT (1'b1),
        .ENABLED     (1'b1)
    ) u_compute (
        .clk             (clk),
        .rst             (reset),
        .tag_ready_vec_i (compute_tag_ready_vec),
        .next_tag_vec_i  (next_compute_tag_vec),
        .done_i          (compute_done),
        .start_o         (compute_start),
        .tag_o           (compute_tag),
        .tag_done_vec_o  (compute_tag_done_vec),
        .idle_o          (cmp_idle)
    );

    tag_stage_sched #(
        .NUM_TAG     (NUM_TAG),
        .TAG_W       (TAG_W),
        .ADV_ON_NEXT (1'b0),
        .ENABLED     (STORE_ENABLED)
    ) u_stmem (
        .clk             (clk),
        .rst             (reset),
        .tag_ready_vec_i (stmem_tag_ready_vec),
        .next_tag_vec_i  ('0),
        .done_i          (stmem_done),
        .start_o         (stmem_start),
        .tag_o           (stmem_tag),
        .tag_done_vec_o  (stmem_tag_done_vec),
        .idle_o          (st_idle)
    );

    assign all_idle = (&tag_ready_vec) && ld_idle && cmp_idle && st_idle;

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
module tb_tag_alloc_ctrl;

    localparam int NT = 2;
    localparam int TW = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          block_start, block_reuse, block_flush, bias_in, ddr_in;
    logic [NT-1:0] tag_ready_vec, ld_rdy, cmp_rdy, st_rdy, next_cmp;
    logic          ld_done, cmp_done, st_done;

    logic          block_ready, tag_bias, tag_ddr, ld_start, cmp_start, st_start, all_idle;
    logic [NT-1:0] tag_req, tag_reuse, tag_flush, ld_dvec, cmp_dvec, st_dvec;
    logic [TW-1:0] ld_tag, cmp_tag, st_tag;

    logic          ns_block_ready, ns_tag_bias, ns_tag_ddr, ns_ld_start, ns_cmp_start, ns_st_start, ns_all_idle;
    logic [NT-1:0] ns_tag_req, ns_tag_reuse, ns_tag_flush, ns_ld_dvec, ns_cmp_dvec, ns_st_dvec;
    logic [TW-1:0] ns_ld_tag, ns_cmp_tag, ns_st_tag;

    tag_alloc_ctrl #(.NUM_TAG(NT), .TAG_W(TW), .STORE_ENABLED(1'b1)) dut (
        .clk(clk), .reset(rst),
        .block_start(block_start), .block_reuse(block_reuse), .block_flush(block_flush),
        .block_bias_prev_sw(bias_in), .block_ddr_pe_sw(ddr_in), .block_ready(block_ready),
        .tag_req(tag_req), .tag_reuse(tag_reuse), .tag_flush(tag_flush),
        .tag_bias_prev_sw(tag_bias), .tag_ddr_pe_sw(tag_ddr), .tag_ready_vec(tag_ready_vec),
        .ldmem_tag_ready_vec(ld_rdy), .compute_tag_ready_vec(cmp_rdy), .stmem_tag_ready_vec(st_rdy),
        .next_compute_tag_vec(next_cmp),
        .ldmem_tag_done_vec(ld_dvec), .compute_tag_done_vec(cmp_dvec), .stmem_tag_done_vec(st_dvec),
        .ldmem_start(ld_start), .compute_start(cmp_start), .stmem_start(st_start),
        .ldmem_tag(ld_tag), .compute_tag(cmp_tag), .stmem_tag(st_tag),
        .ldmem_done(ld_done), .compute_done(cmp_done), .stmem_done(st_done),
        .all_idle(all_idle)
    );

    tag_alloc_ctrl #(.NUM_TAG(NT), .TAG_W(TW), .STORE_ENABLED(1'b0)) dut_ns (
        .clk(clk), .reset(rst),
        .block_start(block_start), .block_reuse(block_reuse), .block_flush(block_flush),
        .block_bias_prev_sw(bias_in), .block_ddr_pe_sw(ddr_in), .block_ready(ns_block_ready),
        .tag_req(ns_tag_req), .tag_reuse(ns_tag_reuse), .tag_flush(ns_tag_flush),
        .tag_bias_prev_sw(ns_tag_bias), .tag_ddr_pe_sw(ns_tag_ddr), .tag_ready_vec(tag_ready_vec),
        .ldmem_tag_ready_vec(ld_rdy), .compute_tag_ready_vec(cmp_rdy), .stmem_tag_ready_vec(st_rdy),
        .next_compute_tag_vec(next_cmp),
        .ldmem_tag_done_vec(ns_ld_dvec), .compute_tag_done_vec(ns_cmp_dvec), .stmem_tag_done_vec(ns_st_dvec),
        .ldmem_start(ns_ld_start), .compute_start(ns_cmp_start), .stmem_start(ns_st_start),
        .ldmem_tag(ns_ld_tag), .compute_tag(ns_cmp_tag), .stmem_tag(ns_st_tag),
        .ldmem_done(ld_done), .compute_done(cmp_done), .stmem_done(st_done),
        .all_idle(ns_all_idle)
    );

    int tests = 0;
    int fails = 0;
    logic ns_st_seen = 1'b0;

    // Scoreboard channels: 0 tag_req, 1 tag_reuse, 2 tag_flush, 3..5 start (tag value), 6..8 done vectors
    localparam int CH_REQ = 0, CH_REUSE = 1, CH_FLUSH = 2, CH_LDS = 3, CH_CMS = 4, CH_STS = 5;
    localparam int CH_LDD = 6, CH_CMD = 7, CH_STD = 8, NCH = 9;
    logic [31:0] exp_q [NCH][$];
    string       ch_name [NCH] = '{"tag_req", "tag_reuse", "tag_flush", "ldmem_start_tag",
                                   "compute_start_tag", "stmem_start_tag", "ldmem_done_vec",
                                   "compute_done_vec", "stmem_done_vec"};
    logic [31:0] obs [NCH];
    logic        vld [NCH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int ch, input logic [31:0] v);
        exp_q[ch].push_back(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output pulse must match the oldest expectation on its channel
    always @(negedge clk) begin
        vld[CH_REQ]   = (tag_req != '0);   obs[CH_REQ]   = 32'(tag_req);
        vld[CH_REUSE] = (tag_reuse != '0); obs[CH_REUSE] = 32'(tag_reuse);
        vld[CH_FLUSH] = (tag_flush != '0); obs[CH_FLUSH] = 32'(tag_flush);
        vld[CH_LDS]   = ld_start;          obs[CH_LDS]   = 32'(ld_tag);
        vld[CH_CMS]   = cmp_start;         obs[CH_CMS]   = 32'(cmp_tag);
        vld[CH_STS]   = st_start;          obs[CH_STS]   = 32'(st_tag);
        vld[CH_LDD]   = (ld_dvec != '0);   obs[CH_LDD]   = 32'(ld_dvec);
        vld[CH_CMD]   = (cmp_dvec != '0);  obs[CH_CMD]   = 32'(cmp_dvec);
        vld[CH_STD]   = (st_dvec != '0);   obs[CH_STD]   = 32'(st_dvec);
        for (int c = 0; c < NCH; c++) begin
            if (vld[c]) begin
                if (exp_q[c].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL %s: unexpected output %0h, expected none", ch_name[c], obs[c]);
                end else begin
                    check(ch_name[c], obs[c], exp_q[c].pop_front());
                end
            end
        end
        if (ns_st_start || ns_st_dvec != '0) ns_st_seen = 1'b1;
    end

    task automatic compute_pass(input logic [TW-1:0] t);
        logic [NT-1:0] oh;
        oh = '0;
        oh[t] = 1'b1;
        cyc(); cmp_rdy = oh; push(CH_CMS, 32'(t));
        cyc(); cmp_rdy = '0;
        @(negedge clk); check("compute_tag_busy", 32'(cmp_tag), 32'(t));
        cyc(); cmp_done = 1'b1; push(CH_CMD, 32'(oh));
        cyc(); cmp_done = 1'b0;
    endtask

    initial begin
        block_start = 0; block_reuse = 0; block_flush = 0; bias_in = 0; ddr_in = 0;
        tag_ready_vec = 2'b11; ld_rdy = '0; cmp_rdy = '0; st_rdy = '0; next_cmp = '0;
        ld_done = 0; cmp_done = 0; st_done = 0;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_block_ready", 32'(block_ready), 1);
        check("rst_all_idle", 32'(all_idle), 1);
        check("rst_ldmem_tag", 32'(ld_tag), 0);
        check("rst_compute_tag", 32'(cmp_tag), 0);
        check("rst_stmem_tag", 32'(st_tag), 0);
        check("rst_bias", 32'(tag_bias), 0);

        // Allocate tag 0 then tag 1; third request stalls until tag 0 is free
        cyc(); block_start = 1; push(CH_REQ, 32'b01);
        @(negedge clk); check("rdy_first", 32'(block_ready), 1);
        cyc(); block_start = 0; tag_ready_vec = 2'b10;
        @(negedge clk); check("rdy_req_inflight", 32'(block_ready), 0);
        cyc(); block_start = 1; push(CH_REQ, 32'b10);
        @(negedge clk); check("rdy_second", 32'(block_ready), 1);
        cyc(); tag_ready_vec = 2'b00;
        @(negedge clk); check("rdy_after_second", 32'(block_ready), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk); check("rdy_stall", 32'(block_ready), 0);
        end
        cyc(); block_start = 0; tag_ready_vec = 2'b01;
        @(negedge clk); check("rdy_released", 32'(block_ready), 1);

        // Load engine on tag 0, done a few cycles after start; stray done while idle ignored
        cyc(); ld_rdy = 2'b01; push(CH_LDS, 0);
        cyc(); ld_rdy = 2'b00;
        @(negedge clk); check("all_idle_busy", 32'(all_idle), 0);
        repeat (4) cyc();
        ld_done = 1; push(CH_LDD, 32'b01);
        cyc();
        @(negedge clk); check("ld_ptr_adv", 32'(ld_tag), 1);
        cyc(); ld_done = 0;
        @(negedge clk); check("ld_ptr_hold", 32'(ld_tag), 1);

        // Two reuse passes on tag 1 with sideband capture
        cyc(); block_reuse = 1; bias_in = 1; ddr_in = 0; push(CH_REUSE, 32'b10);
        cyc(); block_reuse = 0; bias_in = 0;
        @(negedge clk); check("sb_bias_r1", 32'(tag_bias), 1); check("sb_ddr_r1", 32'(tag_ddr), 0);
        cyc(); block_reuse = 1; ddr_in = 1; push(CH_REUSE, 32'b10);
        cyc(); block_reuse = 0; ddr_in = 0;
        @(negedge clk); check("sb_bias_r2", 32'(tag_bias), 0); check("sb_ddr_r2", 32'(tag_ddr), 1);

        // Compute: pass on tag 0, hand off, three passes on tag 1, hand off
        compute_pass(0);
        cyc(); next_cmp = 2'b01;
        cyc(); next_cmp = 2'b00;
        @(negedge clk); check("cmp_ptr_to1", 32'(cmp_tag), 1);
        for (int i = 0; i < 3; i++) compute_pass(1);
        @(negedge clk); check("cmp_ptr_held", 32'(cmp_tag), 1);
        cyc(); next_cmp = 2'b10;
        cyc(); next_cmp = 2'b00;
        @(negedge clk); check("cmp_ptr_wrap", 32'(cmp_tag), 0);

        // Flush coincident with allocation of tag 1 flushes the previous tag 0
        cyc(); tag_ready_vec = 2'b11; block_start = 1; push(CH_REQ, 32'b01);
        cyc(); block_start = 0;
        cyc(); block_start = 1; block_flush = 1; push(CH_REQ, 32'b10); push(CH_FLUSH, 32'b01);
        @(negedge clk); check("rdy_flush_start", 32'(block_ready), 1);
        cyc(); block_start = 0; block_flush = 0;
        @(negedge clk); check("sb_ddr_on_start", 32'(tag_ddr), 0);
        cyc(); block_flush = 1; push(CH_FLUSH, 32'b10);
        cyc(); block_flush = 0;

        // Store engine; the store-disabled instance must stay silent
        cyc(); st_rdy = 2'b11; push(CH_STS, 0);
        cyc(); st_rdy = 2'b00;
        @(negedge clk); check("st_tag_busy", 32'(st_tag), 0);
        cyc(); st_done = 1; push(CH_STD, 32'b01);
        cyc(); st_done = 0;
        @(negedge clk); check("st_ptr_adv", 32'(st_tag), 1);

        // Reset while compute is busy abandons the pass without a done pulse
        cyc(); cmp_rdy = 2'b01; push(CH_CMS, 0);
        cyc(); cmp_rdy = 2'b00;
        cyc(); cmp_done = 1; rst = 1;
        @(negedge clk);
        check("rst_mid_cmp_start", 32'(cmp_start), 0);
        check("rst_mid_cmp_dvec", 32'(cmp_dvec), 0);
        check("rst_mid_ld_tag", 32'(ld_tag), 0);
        check("rst_mid_st_tag", 32'(st_tag), 0);
        check("rst_mid_all_idle", 32'(all_idle), 1);
        cyc(); cmp_done = 0; rst = 0;
        cyc(); block_reuse = 1; block_flush = 1;
        cyc(); block_reuse = 0; block_flush = 0;
        @(negedge clk); check("post_rst_ready", 32'(block_ready), 1);
        repeat (2) cyc();
        @(negedge clk);

        for (int c = 0; c < NCH; c++) check({"drained_", ch_name[c]}, 32'(exp_q[c].size()), 0);
        check("no_store_stmem_silent", 32'(ns_st_seen), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tag_alloc_ctrl.md
TAG_ALLOC_CTRL -- requirements
Module: tag_alloc_ctrl

Interface
REQ-001 SHALL have parameter NUM_TAG, default 2, number of double-buffer tags managed (power of two, at least 2).
REQ-002 SHALL have parameter TAG_W, default 1, tag index width (log2 NUM_TAG).
REQ-003 SHALL have parameter STORE_ENABLED, default 1, store stage present.
REQ-004 SHALL have the following ports:
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high.
- block_start  in  1  request a new tile into a fresh tag.
- block_reuse  in  1  extra compute pass on the last allocated tag.
- block_flush  in  1  last pass of the last allocated tag; store may follow.
- block_bias_prev_sw  in  1  sideband, forwarded with req/reuse.
- block_ddr_pe_sw  in  1  sideband, forwarded with req/reuse.
- block_ready  out  1  block_start accepted this cycle.
- tag_req  out  NUM_TAG  one-hot per-tag allocate pulse.
- tag_reuse  out  NUM_TAG  one-hot per-tag reuse pulse.
- tag_flush  out  NUM_TAG  one-hot per-tag flush pulse.
- tag_bias_prev_sw  out  1  registered sideband.
- tag_ddr_pe_sw  out  1  registered sideband.
- tag_ready_vec  in  NUM_TAG  per-tag free flag.
- ldmem_tag_ready_vec, compute_tag_ready_vec, stmem_tag_ready_vec  in  NUM_TAG each  per-tag stage-ready flags.
- next_compute_tag_vec  in  NUM_TAG  per-tag "compute finished, hand off".
- ldmem_tag_done_vec, compute_tag_done_vec, stmem_tag_done_vec  out  NUM_TAG each  one-hot per-tag stage-done pulses.
- ldmem_start / compute_start / stmem_start  out  1 each  engine start pulse.
- ldmem_tag / compute_tag / stmem_tag  out  TAG_W each  tag served by engine.
- ldmem_done / compute_done / stmem_done  in  1 each  engine completion pulse.
- all_idle  out  1  every tag free and every engine idle.

Function
REQ-005 SHALL keep alloc_ptr; block_ready = tag_ready_vec[alloc_ptr] AND no tag_req pulse in flight.
REQ-006 SHALL, on block_start AND block_ready, assert tag_req[alloc_ptr] for exactly one cycle starting next cycle, register sidebands, set last_ptr = alloc_ptr, and increment alloc_ptr modulo NUM_TAG.
REQ-007 SHALL ignore block_start when block_ready is 0; no state changes.
REQ-008 SHALL, on block_reuse, pulse tag_reuse[last_ptr] one cycle later and register sidebands; block_reuse before any allocation SHALL be ignored.
REQ-009 SHALL, on block_flush, pulse tag_flush[last_ptr] one cycle later; simultaneous block_start and block_flush SHALL flush the previous last_ptr, then update last_ptr.
REQ-010 SHALL run one engine FSM per stage with states IDLE -> BUSY -> IDLE, pointers ld_ptr, cmp_ptr, st_ptr (reset 0), advancing in allocation order.
REQ-011 SHALL, in IDLE, pulse <stage>_start one cycle after <stage>_tag_ready_vec[ptr] is high and enter BUSY; <stage>_tag SHALL equal ptr throughout BUSY.
REQ-012 SHALL, on <stage>_done in BUSY, pulse <stage>_tag_done_vec[ptr] same cycle (combinational) and return to IDLE; done in IDLE SHALL be ignored.
REQ-013 ld_ptr and st_ptr SHALL increment on their done; cmp_ptr SHALL increment only when next_compute_tag_vec[cmp_ptr] is high while IDLE, so reuse passes restart on the same tag.
REQ-014 SHALL, when STORE_ENABLED is 0, hold stmem_start and stmem_tag_done_vec at 0.
REQ-015 all_idle SHALL be AND of tag_ready_vec and all engine FSMs IDLE.

Reset
REQ-016 SHALL asynchronously clear pointers, last_ptr valid flag, engine FSMs to IDLE, sideband registers, and all pulse outputs to 0; mid-operation reset SHALL abandon in-flight passes without emitting done pulses.

Structure
REQ-017 SHALL place engine state encoding (IDLE, BUSY) and TAG_W derivation in a shared package.
REQ-018 SHALL instantiate one sub-module tag_stage_sched three times (ldmem, compute, stmem), parameterised by whether advance uses done or next_compute_tag_vec.

Verification
REQ-019 Allocate tag 0 and tag 1 back-to-back -> tag_req = 01 then 10; third block_start stalls, block_ready = 0 until tag_ready_vec[0] = 1.
REQ-020 Tag 0 ldmem ready, ldmem_done after 5 cycles -> ldmem_start one pulse, ldmem_tag = 0, ldmem_tag_done_vec = 01 on done cycle, ld_ptr = 1.
REQ-021 block_reuse twice after allocating tag 1 -> tag_reuse = 10 twice; compute_start three times with compute_tag = 1 before cmp_ptr advances on next_compute_tag_vec = 10.
REQ-022 block_flush coincident with block_start to tag 1 -> tag_flush = 01, tag_req = 10.
REQ-023 Reset asserted while compute BUSY -> next cycle compute_start = 0, all done vectors 0, pointers 0, all_idle = 1 once tag_ready_vec = 11.
REQ-024 STORE_ENABLED = 0, stmem_tag_ready_vec = 11 -> stmem_start never asserts.
